video_timing_gen: RTL and testbench

Video stream source for the vision pipeline. Generates raster timing (active, hsync, vsync) plus a synthetic pixel pattern on the same four-signal video interface the morphological filter chain consumes. Used to drive filter blocks on hardware and in simulation without a camera or HDMI input. Sits at the head of the pipeline, feeding `in_active/in_data/in_hsync/in_vsync` of downstream filters.

---
 rtl/video_timing_pkg.sv | 14 +
 rtl/video_timing_gen_if.sv | 28 ++
 rtl/vtg_pattern.sv | 42 ++++
 rtl/video_timing_gen.sv | 150 +++++++++++++++
 tb/tb_video_timing_gen.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator: pattern codes and FSM state encoding.
package video_timing_pkg;

  localparam logic [1:0] PAT_HRAMP   = 2'd0;
  localparam logic [1:0] PAT_VRAMP   = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_SOLID   = 2'd3;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } vtg_state_e;

endpackage

// File: rtl/video_timing_gen_if.sv
// Four-signal raster video stream plus frame-start marker, as consumed by the filter chain.
interface video_timing_gen_if #(
  parameter int unsigned VIDEO_DATA_WIDTH = 8
) ();

  logic                        out_active;
  logic [VIDEO_DATA_WIDTH-1:0] out_data;
  logic                        out_hsync;
  logic                        out_vsync;
  logic                        out_frame_start;

  modport master (
    output out_active,
    output out_data,
    output out_hsync,
    output out_vsync,
    output out_frame_start
  );

  modport slave (
    input out_active,
    input out_data,
    input out_hsync,
    input out_vsync,
    input out_frame_start
  );

endinterface

// File: rtl/vtg_pattern.sv
// Combinational synthetic pixel generator driven by the raster counters and the latched pattern.
module vtg_pattern
  import video_timing_pkg::*;
#(
  parameter int unsigned HCntWidth = 11,
  parameter int unsigned VCntWidth = 10,
  parameter int unsigned DataWidth = 8
) (
  input  logic [HCntWidth-1:0] h_cnt_i,
  input  logic [VCntWidth-1:0] v_cnt_i,
  input  logic [1:0]           pattern_i,
  output logic [DataWidth-1:0] pixel_o
);

  logic h_b5;
  logic v_b5;

  // Counters narrower than 6 bits never reach a 32-pixel tile boundary.
  if (HCntWidth > 5) begin : g_h_b5
    assign h_b5 = h_cnt_i[5];
  end else begin : g_h_b5_zero
    assign h_b5 = 1'b0;
  end

  if (VCntWidth > 5) begin : g_v_b5
    assign v_b5 = v_cnt_i[5];
  end else begin : g_v_b5_zero
    assign v_b5 = 1'b0;
  end

  always_comb begin
    pixel_o = '0;
    case (pattern_i)
      PAT_HRAMP:   pixel_o = DataWidth'(h_cnt_i);
      PAT_VRAMP:   pixel_o = DataWidth'(v_cnt_i);
      PAT_CHECKER: pixel_o = (h_b5 ^ v_b5) ? '1 : '0;
      PAT_SOLID:   pixel_o = '1;
      default:     pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source. Define VTG_PATTERN_EN to honour pattern_sel;
// otherwise the pixel stream is always the horizontal ramp.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = 1280,
  parameter int unsigned H_FP             = 110,
  parameter int unsigned H_SYNC           = 40,
  parameter int unsigned H_BP             = 220,
  parameter int unsigned V_ACTIVE         = 720,
  parameter int unsigned V_FP             = 5,
  parameter int unsigned V_SYNC           = 5,
  parameter int unsigned V_BP             = 20,
  parameter int unsigned VIDEO_DATA_WIDTH = 8,
  parameter bit          SYNC_POL         = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActLast   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HSyncFirst = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncLast  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActLast   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VSyncFirst = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncLast  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  vtg_state_e state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    pat_q, pat_d;

  logic                        active_q, active_d;
  logic [VIDEO_DATA_WIDTH-1:0] data_q, data_d;
  logic                        hsync_q, hsync_d;
  logic                        vsync_q, vsync_d;
  logic                        frame_start_q, frame_start_d;

  logic                        frame_end;
  logic                        run;
  logic [VIDEO_DATA_WIDTH-1:0] pixel;

  // Counter / FSM next state
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    frame_end = (h_cnt_q == HLast) && (v_cnt_q == VLast);
    case (state_q)
      StIdle: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (h_cnt_q == HLast) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
        // Enable only takes effect on frame boundaries so no partial frame is emitted.
        if (frame_end && !enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef VTG_PATTERN_EN
  // Latch the pattern on the edge that loads (0,0) so it is valid for the whole frame.
  always_comb begin
    pat_d = pat_q;
    if ((state_d == StRun) && (h_cnt_d == '0) && (v_cnt_d == '0)) begin
      pat_d = pattern_sel;
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel;
  assign pat_d              = PAT_HRAMP;
`endif

  vtg_pattern #(
    .HCntWidth (HW),
    .VCntWidth (VW),
    .DataWidth (VIDEO_DATA_WIDTH)
  ) u_pattern (
    .h_cnt_i   (h_cnt_q),
    .v_cnt_i   (v_cnt_q),
    .pattern_i (pat_q),
    .pixel_o   (pixel)
  );

  // Output decode: all five outputs derive from the same counter state.
  always_comb begin
    run           = (state_q == StRun);
    active_d      = run && (h_cnt_q <= HActLast) && (v_cnt_q <= VActLast);
    data_d        = active_d ? pixel : '0;
    hsync_d       = (run && (h_cnt_q >= HSyncFirst) && (h_cnt_q <= HSyncLast)) ?
                    SYNC_POL : ~SYNC_POL;
    vsync_d       = (run && (v_cnt_q >= VSyncFirst) && (v_cnt_q <= VSyncLast)) ?
                    SYNC_POL : ~SYNC_POL;
    frame_start_d = run && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pat_q         <= PAT_HRAMP;
      active_q      <= 1'b0;
      data_q        <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pat_q         <= pat_d;
      active_q      <= active_d;
      data_q        <= data_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.out_active      = active_q;
  assign vid.out_data        = data_q;
  assign vid.out_hsync       = hsync_q;
  assign vid.out_vsync       = vsync_q;
  assign vid.out_frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small raster, 64x64 pattern raster, inverted sync polarity.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_s = 1'b1, en_s = 1'b1;
  logic [1:0] pat_s = 2'd0;
  logic       rst_c = 1'b1, en_c = 1'b1;
  logic [1:0] pat_c = 2'd2;
  logic       rst_n = 1'b1, en_n = 1'b1;
  logic [1:0] pat_n = 2'd0;

  video_timing_gen_if #(.VIDEO_DATA_WIDTH(8)) vid_s ();
  video_timing_gen_if #(.VIDEO_DATA_WIDTH(8)) vid_c ();
  video_timing_gen_if #(.VIDEO_DATA_WIDTH(8)) vid_n ();

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .VIDEO_DATA_WIDTH(8), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst_s), .enable(en_s), .pattern_sel(pat_s), .vid(vid_s)
  );

  video_timing_gen #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(64), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .VIDEO_DATA_WIDTH(8), .SYNC_POL(1'b1)
  ) u_chk (
    .clk(clk), .rst(rst_c), .enable(en_c), .pattern_sel(pat_c), .vid(vid_c)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .VIDEO_DATA_WIDTH(8), .SYNC_POL(1'b0)
  ) u_neg (
    .clk(clk), .rst(rst_n), .enable(en_n), .pattern_sel(pat_n), .vid(vid_n)
  );

  // {active, data[7:0], hsync, vsync, frame_start}
  logic [11:0] obs_s, obs_c, obs_n;
  assign obs_s = {vid_s.out_active, vid_s.out_data, vid_s.out_hsync, vid_s.out_vsync,
                  vid_s.out_frame_start};
  assign obs_c = {vid_c.out_active, vid_c.out_data, vid_c.out_hsync, vid_c.out_vsync,
                  vid_c.out_frame_start};
  assign obs_n = {vid_n.out_active, vid_n.out_data, vid_n.out_hsync, vid_n.out_vsync,
                  vid_n.out_frame_start};

`ifdef VTG_PATTERN_EN
  localparam logic [7:0] SpotA = 8'h00, SpotB = 8'hff, SpotC = 8'h00, SpotD = 8'hff;
`else
  localparam logic [7:0] SpotA = 8'd31, SpotB = 8'd32, SpotC = 8'd32, SpotD = 8'd5;
`endif

  // Reference raster: t counts output samples from the first frame_start.
  function automatic logic [11:0] exp_vec(int t, int ht, int vt, int ha, int va, int hss,
                                          int hsw, int vss, int vsw, int pat, bit pol);
    int h, v, p;
    logic act;
    logic [7:0] d;
    h = t % ht;
    v = (t / ht) % vt;
    p = pat;
`ifndef VTG_PATTERN_EN
    p = 0;
`endif
    act = (h < ha) && (v < va);
    d = 8'h00;
    if (act) begin
      case (p)
        0:       d = 8'(h);
        1:       d = 8'(v);
        2:       d = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 8'hff : 8'h00;
        default: d = 8'hff;
      endcase
    end
    return {act, d, (h >= hss && h < hss + hsw) ? pol : ~pol,
            (v >= vss && v < vss + vsw) ? pol : ~pol, (h == 0 && v == 0)};
  endfunction

  function automatic logic [11:0] idle_vec(bit pol);
    return {1'b0, 8'h00, ~pol, ~pol, 1'b0};
  endfunction

  int t_s;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_s !== idle_vec(1'b1)) begin
      errors++; $display("FAIL reset_small got %h exp %h", obs_s, idle_vec(1'b1));
    end
    checks++;
    if (obs_c !== idle_vec(1'b1)) begin
      errors++; $display("FAIL reset_chk got %h exp %h", obs_c, idle_vec(1'b1));
    end
    checks++;
    if (obs_n !== idle_vec(1'b0)) begin
      errors++; $display("FAIL reset_neg got %h exp %h", obs_n, idle_vec(1'b0));
    end
  endtask

  task automatic test_start();
    rst_s = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_s !== idle_vec(1'b1)) begin
      errors++; $display("FAIL start_latency got %h exp %h", obs_s, idle_vec(1'b1));
    end
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== exp_vec(i, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1)) begin
        errors++; $display("FAIL start t=%0d got %h exp %h", i, obs_s,
                           exp_vec(i, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1));
      end
    end
    t_s = 8;
  endtask

  task automatic test_free_run();
    int fs_cnt = 0, vs_cnt = 0, hs_cnt = 0, last_fs = 0;
    for (int t = 9; t <= 302; t++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1)) begin
        errors++; $display("FAIL free_run t=%0d got %h exp %h", t, obs_s,
                           exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1));
      end
      if (vid_s.out_vsync === 1'b1) vs_cnt++;
      if (vid_s.out_hsync === 1'b1) hs_cnt++;
      if (vid_s.out_frame_start === 1'b1) begin
        checks++;
        if (t - last_fs !== 98) begin
          errors++; $display("FAIL frame_period got %0d exp 98", t - last_fs);
        end
        last_fs = t;
        fs_cnt++;
      end
    end
    checks++;
    if (fs_cnt !== 3) begin
      errors++; $display("FAIL frame_count got %0d exp 3", fs_cnt);
    end
    checks++;
    if (vs_cnt !== 42) begin
      errors++; $display("FAIL vsync_cycles got %0d exp 42", vs_cnt);
    end
    checks++;
    if (hs_cnt !== 42) begin
      errors++; $display("FAIL hsync_cycles got %0d exp 42", hs_cnt);
    end
    t_s = 302;
  endtask

  task automatic test_pattern_switch();
    int pat;
    pat_s = 2'd1;
    for (int t = t_s + 1; t <= 489; t++) begin
      @(negedge clk);
      pat = (t < 392) ? 0 : 1;
      checks++;
      if (obs_s !== exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, pat, 1'b1)) begin
        errors++; $display("FAIL pattern_switch t=%0d got %h exp %h", t, obs_s,
                           exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, pat, 1'b1));
      end
      if (t == 420) pat_s = 2'd0;
    end
    t_s = 489;
  endtask

  task automatic test_enable_drop();
    logic [11:0] e;
    for (int t = t_s + 1; t <= 599; t++) begin
      @(negedge clk);
      e = (t < 588) ? exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1) : idle_vec(1'b1);
      checks++;
      if (obs_s !== e) begin
        errors++; $display("FAIL enable_drop t=%0d got %h exp %h", t, obs_s, e);
      end
      if (t == 500) en_s = 1'b0;
    end
    en_s = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_s !== idle_vec(1'b1)) begin
      errors++; $display("FAIL reenable_latency got %h exp %h", obs_s, idle_vec(1'b1));
    end
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== exp_vec(i, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1)) begin
        errors++; $display("FAIL reenable t=%0d got %h exp %h", i, obs_s,
                           exp_vec(i, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b1));
      end
    end
  endtask

  task automatic test_checker();
    int pat;
    rst_c = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_c !== idle_vec(1'b1)) begin
      errors++; $display("FAIL chk_latency got %h exp %h", obs_c, idle_vec(1'b1));
    end
    for (int t = 0; t < 9380; t++) begin
      @(negedge clk);
      pat = (t < 4690) ? 2 : 3;
      checks++;
      if (obs_c !== exp_vec(t, 70, 67, 64, 64, 66, 2, 65, 1, pat, 1'b1)) begin
        errors++; $display("FAIL checker t=%0d got %h exp %h", t, obs_c,
                           exp_vec(t, 70, 67, 64, 64, 66, 2, 65, 1, pat, 1'b1));
      end
      if (t == 31) begin
        checks++;
        if (vid_c.out_data !== SpotA) begin
          errors++; $display("FAIL pix_31_0 got %h exp %h", vid_c.out_data, SpotA);
        end
      end
      if (t == 32) begin
        checks++;
        if (vid_c.out_data !== SpotB) begin
          errors++; $display("FAIL pix_32_0 got %h exp %h", vid_c.out_data, SpotB);
        end
      end
      if (t == 32 * 70 + 32) begin
        checks++;
        if (vid_c.out_data !== SpotC) begin
          errors++; $display("FAIL pix_32_32 got %h exp %h", vid_c.out_data, SpotC);
        end
      end
      if (t == 4690 + 5) begin
        checks++;
        if (vid_c.out_data !== SpotD) begin
          errors++; $display("FAIL solid_pix got %h exp %h", vid_c.out_data, SpotD);
        end
      end
      if (t == 4690 + 64) begin
        checks++;
        if (vid_c.out_data !== 8'h00) begin
          errors++; $display("FAIL solid_blank got %h exp 00", vid_c.out_data);
        end
      end
      if (t == 100) pat_c = 2'd3;
    end
  endtask

  task automatic test_sync_neg();
    rst_n = 1'b0;
    @(negedge clk);
    for (int t = 0; t <= 10; t++) begin
      @(negedge clk);
      checks++;
      if (obs_n !== exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b0)) begin
        errors++; $display("FAIL neg_run t=%0d got %h exp %h", t, obs_n,
                           exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b0));
      end
    end
    checks++;
    if (vid_n.out_hsync !== 1'b0) begin
      errors++; $display("FAIL neg_hsync_low got %b exp 0", vid_n.out_hsync);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_n !== idle_vec(1'b0)) begin
      errors++; $display("FAIL neg_reset_hsync got %h exp %h", obs_n, idle_vec(1'b0));
    end
    rst_n = 1'b0;
    @(negedge clk);
    for (int t = 0; t <= 72; t++) begin
      @(negedge clk);
      checks++;
      if (obs_n !== exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b0)) begin
        errors++; $display("FAIL neg_run2 t=%0d got %h exp %h", t, obs_n,
                           exp_vec(t, 14, 7, 8, 4, 10, 2, 5, 1, 0, 1'b0));
      end
    end
    checks++;
    if (vid_n.out_vsync !== 1'b0) begin
      errors++; $display("FAIL neg_vsync_low got %b exp 0", vid_n.out_vsync);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_n !== idle_vec(1'b0)) begin
      errors++; $display("FAIL neg_reset_vsync got %h exp %h", obs_n, idle_vec(1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_free_run();
    test_pattern_switch();
    test_enable_drop();
    test_checker();
    test_sync_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
